// File: rtl/muldiv_sequencer.sv
// Sequential RISC-V M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle combinational multiply path).
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  // MULH, MULHSU, DIV and REM take rs1 as signed; MULH, DIV and REM also rs2.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

  logic            accept;
  logic            in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    accept   = ((state_q == IDLE) || (state_q == DONE)) && start_i && !flush_i;
    in_a_neg = op_signed_a(op_i) && rs1_i[XLEN-1];
    in_b_neg = op_signed_b(op_i) && rs2_i[XLEN-1];
    in_a_mag = in_a_neg ? (~rs1_i + 1'b1) : rs1_i;
    in_b_mag = in_b_neg ? (~rs2_i + 1'b1) : rs2_i;
    a_neg    = op_signed_a(op_q) && rs1_q[XLEN-1];
    b_neg    = op_signed_b(op_q) && rs2_q[XLEN-1];
    a_mag    = a_neg ? (~rs1_q + 1'b1) : rs1_q;
    b_mag    = b_neg ? (~rs2_q + 1'b1) : rs2_q;
  end

  // Multiply step: {acc, lo} is the partial product; lo starts as |rs2| and shifts out.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_signed;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    mul_next   = {mul_sum, lo_q[XLEN-1:1]};
    mul_signed = (a_neg ^ b_neg) ? (~mul_next + 1'b1) : mul_next;
    mul_res    = (op_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
  end

  // Divide step: acc is the partial remainder, lo holds the dividend shifting into quotient.
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] div_rem_next;
  logic [XLEN-1:0] div_quo_next;
  logic [XLEN-1:0] div_quo_s;
  logic [XLEN-1:0] div_rem_s;
  logic [XLEN-1:0] div_res;

  always_comb begin
    div_shift    = {acc_q, lo_q[XLEN-1]};
    div_diff     = div_shift - {1'b0, b_mag};
    div_ok       = !div_diff[XLEN];
    div_rem_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_next = {lo_q[XLEN-2:0], div_ok};
    div_quo_s    = (a_neg ^ b_neg) ? (~div_quo_next + 1'b1) : div_quo_next;
    div_rem_s    = a_neg ? (~div_rem_next + 1'b1) : div_rem_next;
    // Divide by zero is forced explicitly so the sign fix-up cannot disturb it.
    if (rs2_q == '0) begin
      div_res = op_q[1] ? rs1_q : {XLEN{1'b1}};
    end else begin
      div_res = op_q[1] ? div_rem_s : div_quo_s;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fast_prod = $signed({in_a_neg, rs1_i}) * $signed({op_signed_b(op_i) && rs2_i[XLEN-1], rs2_i});
    fast_res  = (op_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d    = op_i;
          rs1_d   = rs1_i;
          rs2_d   = rs2_i;
          cnt_d   = 5'd0;
          acc_d   = '0;
          lo_d    = op_i[2] ? in_a_mag : in_b_mag;
          state_d = op_i[2] ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
          if (!op_i[2]) begin
            state_d  = DONE;
            result_d = fast_res;
          end
`endif
        end
      end
      MUL: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = mul_next[2*XLEN-1:XLEN];
        lo_d  = mul_next[XLEN-1:0];
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = mul_res;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = div_rem_next;
        lo_d  = div_quo_next;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = div_res;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a completion on this same edge.
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      cnt_q    <= 5'd0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == MUL) || (state_q == DIV);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule
